stopwatch_controller: RTL and testbench

//  Sequences the stopwatch timebase. Decodes start/stop, clear and lap command pulses in an FSM.

---
 rtl/stopwatch_controller_if.sv | 22 ++
 rtl/stopwatch_controller.sv | 119 +++++++++++
 tb/tb_stopwatch_controller.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_controller_if.sv
// Command/status bundle between the button front-end, the stopwatch timebase and the display driver.
// master = command source and display consumer, slave = stopwatch_controller.
interface stopwatch_controller_if;
  logic        start_stop_p;
  logic        clear_p;
  logic        lap_p;
  logic        running;
  logic        tick;
  logic        wrap;
  logic        lap_active;
  logic [15:0] digits;

  modport master (
    output start_stop_p, clear_p, lap_p,
    input  running, tick, wrap, lap_active, digits
  );

  modport slave (
    input  start_stop_p, clear_p, lap_p,
    output running, tick, wrap, lap_active, digits
  );
endinterface

// File: rtl/stopwatch_controller.sv
// Stopwatch timebase: IDLE/RUN/PAUSE FSM, centisecond prescaler and 4-digit BCD SS.CC counter.
// Define STOPWATCH_LAP_EN to add the lap-freeze display latch.
module stopwatch_controller #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input logic                   clk,
  input logic                   rst,
  stopwatch_controller_if.slave bus
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state_reg;
  logic          running_reg;
  logic [PW-1:0] presc_reg;
  logic [15:0]   count_reg;
  logic [15:0]   count_next;
  logic [4:0]    carry;
  logic          tick_now;

  assign tick_now = (state_reg == RUN) && (presc_reg == PRESC_MAX);

  // Ripple-carry BCD increment; digit 3 (seconds tens) rolls over at 5, the rest at 9.
  assign carry[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      localparam logic [3:0] LIM = (gi == 3) ? 4'd5 : 4'd9;
      logic at_max;
      assign at_max       = (count_reg[4*gi +: 4] == LIM);
      assign carry[gi+1]  = carry[gi] & at_max;
      assign count_next[4*gi +: 4] = !carry[gi] ? count_reg[4*gi +: 4] :
                                     at_max     ? 4'd0 :
                                                  count_reg[4*gi +: 4] + 4'd1;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      running_reg <= 1'b0;
      presc_reg   <= '0;
      count_reg   <= '0;
    end else begin
      if (state_reg == RUN) begin
        presc_reg <= tick_now ? '0 : presc_reg + 1'b1;
        if (tick_now)
          count_reg <= count_next;
      end
      case (state_reg)
        IDLE: begin
          if (bus.start_stop_p) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
            presc_reg   <= '0;
          end
        end
        RUN: begin
          if (bus.start_stop_p) begin
            state_reg   <= PAUSE;
            running_reg <= 1'b0;
          end
        end
        PAUSE: begin
          // Clear outranks a simultaneous resume; the prescaler is otherwise held.
          if (bus.clear_p) begin
            state_reg   <= IDLE;
            running_reg <= 1'b0;
            count_reg   <= '0;
            presc_reg   <= '0;
          end else if (bus.start_stop_p) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          running_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.running = running_reg;
  assign bus.tick    = tick_now;
  assign bus.wrap    = tick_now & carry[4];

`ifdef STOPWATCH_LAP_EN
  logic        lap_reg;
  logic [15:0] latch_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_reg   <= 1'b0;
      latch_reg <= '0;
    end else if (state_reg == PAUSE && bus.clear_p) begin
      lap_reg <= 1'b0;
    end else if (bus.lap_p) begin
      if (lap_reg && state_reg != IDLE) begin
        lap_reg <= 1'b0;
      end else if (!lap_reg && state_reg == RUN) begin
        lap_reg   <= 1'b1;
        latch_reg <= count_reg;
      end
    end
  end

  assign bus.lap_active = lap_reg;
  assign bus.digits     = lap_reg ? latch_reg : count_reg;
`else
  logic unused_lap;
  assign unused_lap     = bus.lap_p;
  assign bus.lap_active = 1'b0;
  assign bus.digits     = count_reg;
`endif
endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench for stopwatch_controller at CLK_HZ=1000, TICK_HZ=100 (DIV=10).
// Vector table, directed corner sequences and random pulses against a centisecond-counting model.
module tb_stopwatch_controller;
  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stopwatch_controller_if sw_if ();

  stopwatch_controller #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sw_if.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: elapsed centiseconds as a plain integer, phase within the current period.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE} mstate_t;
  mstate_t m_state;
  int      m_phase;
  int      m_cs;
  int      m_lap_cs;
  bit      m_lap;

  function automatic logic [15:0] to_bcd(input int cs);
    int s;
    int c;
    s = cs / 100;
    c = cs % 100;
    return {4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic bit m_tick();
    return (m_state == M_RUN) && (m_phase == DIV - 1);
  endfunction

  task automatic m_reset();
    m_state = M_IDLE; m_phase = 0; m_cs = 0; m_lap_cs = 0; m_lap = 1'b0;
  endtask

  task automatic m_advance(input bit ss, input bit clr, input bit lap);
    bit      t;
    mstate_t s;
    int      old_cs;
    t = m_tick(); s = m_state; old_cs = m_cs;
    if (s == M_RUN) begin
      m_phase = (m_phase + 1) % DIV;
      if (t) m_cs = (m_cs + 1) % 6000;
    end
    if (LAP_EN && lap) begin
      if (m_lap && s != M_IDLE) m_lap = 1'b0;
      else if (!m_lap && s == M_RUN) begin m_lap = 1'b1; m_lap_cs = old_cs; end
    end
    case (s)
      M_IDLE:  if (ss) begin m_state = M_RUN; m_phase = 0; end
      M_RUN:   if (ss) m_state = M_PAUSE;
      M_PAUSE: if (clr) begin m_state = M_IDLE; m_cs = 0; m_phase = 0; m_lap = 1'b0; end
               else if (ss) m_state = M_RUN;
      default: m_state = M_IDLE;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("running", 32'(sw_if.running), 32'(m_state == M_RUN));
    check("tick", 32'(sw_if.tick), 32'(m_tick()));
    check("wrap", 32'(sw_if.wrap), 32'(m_tick() && m_cs == 5999));
    check("lap_active", 32'(sw_if.lap_active), 32'(m_lap));
    check("digits", 32'(sw_if.digits), 32'(m_lap ? to_bcd(m_lap_cs) : to_bcd(m_cs)));
  endtask

  // One clock: compare outputs of the current state, then apply inputs across the edge.
  task automatic cycle(input bit ss, input bit clr, input bit lap);
    sw_if.start_stop_p = ss;
    sw_if.clear_p      = clr;
    sw_if.lap_p        = lap;
    check_model();
    m_advance(ss, clr, lap);
    @(posedge clk);
    #1;
    sw_if.start_stop_p = 1'b0;
    sw_if.clear_p      = 1'b0;
    sw_if.lap_p        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sw_if.start_stop_p = 1'b0; sw_if.clear_p = 1'b0; sw_if.lap_p = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  typedef struct {
    bit          ss;
    bit          clr;
    int          idle_n;
    bit          running;
    bit          tick;
    logic [15:0] digits;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int ticks;
    int wraps;
    bit seen_top;
    bit bad_wrap;

    vecs[0] = '{1'b0, 1'b1,  0, 1'b0, 1'b0, 16'h0000}; // clear in IDLE
    vecs[1] = '{1'b1, 1'b0,  0, 1'b1, 1'b0, 16'h0000}; // start
    vecs[2] = '{1'b0, 1'b1, 24, 1'b1, 1'b0, 16'h0002}; // clear in RUN ignored
    vecs[3] = '{1'b1, 1'b0, 30, 1'b0, 1'b0, 16'h0002}; // pause, held
    vecs[4] = '{1'b1, 1'b0,  3, 1'b1, 1'b1, 16'h0002}; // resume, phase 9
    vecs[5] = '{1'b0, 1'b0,  1, 1'b1, 1'b0, 16'h0003};
    vecs[6] = '{1'b1, 1'b1,  0, 1'b0, 1'b0, 16'h0003}; // start+clear in RUN -> PAUSE
    vecs[7] = '{1'b1, 1'b1,  0, 1'b0, 1'b0, 16'h0000}; // start+clear in PAUSE -> IDLE
    vecs[8] = '{1'b1, 1'b1,  9, 1'b1, 1'b1, 16'h0000}; // start+clear in IDLE -> RUN
    vecs[9] = '{1'b0, 1'b0,  0, 1'b1, 1'b0, 16'h0001};

    do_reset();
    check("reset digits", 32'(sw_if.digits), 32'h0000);
    check("reset running", 32'(sw_if.running), 32'h0);
    check("reset lap_active", 32'(sw_if.lap_active), 32'h0);
    $display("reset: digits=%h running=%b", sw_if.digits, sw_if.running);

    foreach (vecs[i]) begin
      cycle(vecs[i].ss, vecs[i].clr, 1'b0);
      idle(vecs[i].idle_n);
      check($sformatf("vec%0d running", i), 32'(sw_if.running), 32'(vecs[i].running));
      check($sformatf("vec%0d tick", i), 32'(sw_if.tick), 32'(vecs[i].tick));
      check($sformatf("vec%0d digits", i), 32'(sw_if.digits), 32'(vecs[i].digits));
      $display("vec%0d: ss=%b clr=%b idle=%0d -> running=%b tick=%b digits=%h",
               i, vecs[i].ss, vecs[i].clr, vecs[i].idle_n, sw_if.running, sw_if.tick, sw_if.digits);
    end

    // Asynchronous reset in a tick cycle clears outputs without waiting for an edge.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    idle(39);
    check("pre-reset tick", 32'(sw_if.tick), 32'h1);
    rst = 1'b1;
    #2;
    check("async rst digits", 32'(sw_if.digits), 32'h0000);
    check("async rst running", 32'(sw_if.running), 32'h0);
    check("async rst tick", 32'(sw_if.tick), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    idle(5);
    check("post-reset running", 32'(sw_if.running), 32'h0);
    $display("async reset: digits=%h running=%b", sw_if.digits, sw_if.running);

    // 100 cycles of RUN give exactly 10 ticks.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    ticks = 0;
    for (int k = 0; k < 100; k++) begin
      if (sw_if.tick) ticks++;
      cycle(1'b0, 1'b0, 1'b0);
    end
    check("100cyc ticks", 32'(ticks), 32'd10);
    check("100cyc digits", 32'(sw_if.digits), 32'h0010);
    check("100cyc running", 32'(sw_if.running), 32'h1);
    $display("run 100: ticks=%0d digits=%h", ticks, sw_if.digits);

    // Pause preserves a partial period.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    idle(14);
    cycle(1'b1, 1'b0, 1'b0);
    idle(50);
    check("pause digits", 32'(sw_if.digits), 32'h0001);
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("resume tick c%0d", k), 32'(sw_if.tick), 32'(k == 5));
      cycle(1'b0, 1'b0, 1'b0);
    end
    check("resume digits", 32'(sw_if.digits), 32'h0002);
    $display("pause/resume: digits=%h", sw_if.digits);

    // Full roll-over: 6000 ticks from 00.00.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    wraps = 0; seen_top = 1'b0; bad_wrap = 1'b0;
    for (int k = 0; k < 6000 * DIV; k++) begin
      if (sw_if.digits == 16'h5999) seen_top = 1'b1;
      if (sw_if.wrap) begin
        wraps++;
        if (!sw_if.tick) bad_wrap = 1'b1;
      end
      cycle(1'b0, 1'b0, 1'b0);
    end
    check("wrap count", 32'(wraps), 32'd1);
    check("wrap w/o tick", 32'(bad_wrap), 32'h0);
    check("saw 59.99", 32'(seen_top), 32'h1);
    check("after wrap digits", 32'(sw_if.digits), 32'h0000);
    check("after wrap running", 32'(sw_if.running), 32'h1);
    $display("rollover: wraps=%0d digits=%h", wraps, sw_if.digits);

    // Pause at 00.12, then start+clear together returns to IDLE.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    idle(60);
    cycle(1'b0, 1'b1, 1'b0);
    idle(59);
    check("clear in RUN digits", 32'(sw_if.digits), 32'h0012);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("start+clear digits", 32'(sw_if.digits), 32'h0000);
    check("start+clear running", 32'(sw_if.running), 32'h0);
    $display("start+clear in PAUSE: digits=%h running=%b", sw_if.digits, sw_if.running);

`ifdef STOPWATCH_LAP_EN
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    idle(50);
    cycle(1'b0, 1'b0, 1'b1);
    idle(149);
    check("lap frozen digits", 32'(sw_if.digits), 32'h0005);
    check("lap frozen active", 32'(sw_if.lap_active), 32'h1);
    cycle(1'b0, 1'b0, 1'b1);
    check("lap release digits", 32'(sw_if.digits), 32'h0020);
    check("lap release active", 32'(sw_if.lap_active), 32'h0);
    $display("lap: digits=%h lap_active=%b", sw_if.digits, sw_if.lap_active);
`else
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    idle(50);
    cycle(1'b0, 1'b0, 1'b1);
    idle(149);
    check("lap ignored digits", 32'(sw_if.digits), 32'h0020);
    check("lap ignored active", 32'(sw_if.lap_active), 32'h0);
    $display("lap disabled: digits=%h lap_active=%b", sw_if.digits, sw_if.lap_active);
`endif

    // Random command pulses, model checked every cycle.
    do_reset();
    for (int k = 0; k < 4000; k++)
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0);
    $display("random: 4000 cycles, final digits=%h running=%b", sw_if.digits, sw_if.running);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
